// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard/sequencing controller:
// MIPS opcode/funct values, PC source encodings and the controller FSM states.
package pipe_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;
   localparam logic [5:0] FUNCT_JR = 6'h08;

   localparam logic [1:0] PC_SRC_PC4    = 2'b00;
   localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
   localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
   localparam logic [1:0] PC_SRC_RS     = 2'b11;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      HALT  = 2'd2
   } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side view of the hazard controller: ID/EX/MEM status coming in,
// PC / IF-ID / ID-EX control going out. The datapath is the master, the
// controller the slave.
interface pipe_ctrl_if;

   logic [31:0] id_instr;
   logic        id_stop;
   logic        id_equal;
   logic        ex_reg_write;
   logic        ex_mem_read;
   logic [4:0]  ex_dst;
   logic        mem_mem_read;
   logic [4:0]  mem_dst;

   logic        pc_write;
   logic        ifid_write;
   logic        ifid_flush;
   logic        idex_bubble;
   logic [1:0]  pc_src;
   logic        draining;
   logic        halted;

   modport master (
      output id_instr, id_stop, id_equal, ex_reg_write, ex_mem_read, ex_dst,
             mem_mem_read, mem_dst,
      input  pc_write, ifid_write, ifid_flush, idex_bubble, pc_src, draining, halted
   );

   modport slave (
      input  id_instr, id_stop, id_equal, ex_reg_write, ex_mem_read, ex_dst,
             mem_mem_read, mem_dst,
      output pc_write, ifid_write, ifid_flush, idex_bubble, pc_src, draining, halted
   );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_unit.sv
// Combinational hazard detection for the ID-stage instruction: which source
// registers it reads, load-use hazards, and operand hazards for instructions
// that resolve in ID (BEQ, BNE, JR).
module hazard_unit
   import pipe_ctrl_pkg::*;
(
   input  logic [5:0] op,
   input  logic [4:0] rs,
   input  logic [4:0] rt,
   input  logic [5:0] funct,
   input  logic       ex_reg_write,
   input  logic       ex_mem_read,
   input  logic [4:0] ex_dst,
   input  logic       mem_mem_read,
   input  logic [4:0] mem_dst,
   output logic       uses_rs,
   output logic       uses_rt,
   output logic       load_use,
   output logic       br_hazard
);

   logic is_id_resolved;
   logic ex_match;
   logic mem_match;

   // Source-use decode, destination matching (register 0 never matches) and hazards.
   always_comb begin
      uses_rs        = (op != OP_J) && (op != OP_JAL);
      uses_rt        = (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
      is_id_resolved = (op == OP_BEQ) || (op == OP_BNE) ||
                       ((op == OP_RTYPE) && (funct == FUNCT_JR));

      ex_match  = (ex_dst != 5'd0) &&
                  ((uses_rs && (ex_dst == rs)) || (uses_rt && (ex_dst == rt)));
      mem_match = (mem_dst != 5'd0) &&
                  ((uses_rs && (mem_dst == rs)) || (uses_rt && (mem_dst == rt)));

      load_use  = ex_mem_read && ex_match;
      br_hazard = is_id_resolved &&
                  ((ex_reg_write && ex_match) || (mem_mem_read && mem_match));
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage MIPS pipeline.
// Stalls on load-use and branch-operand hazards, redirects on taken
// branches/jumps, and on the stop word drains EX/MEM/WB and then halts.
// Optional statistics counters: define PIPE_CTRL_STATS_EN.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int DRAIN_CYCLES = 3,
   parameter int STAT_W       = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   pipe_ctrl_if.slave        bus
`ifdef PIPE_CTRL_STATS_EN
   ,
   output logic [STAT_W-1:0] stat_cycles,
   output logic [STAT_W-1:0] stat_stalls,
   output logic [STAT_W-1:0] stat_flushes
`endif
);

   localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   logic [5:0] op;
   logic [4:0] rs;
   logic [4:0] rt;
   logic [5:0] funct;
   logic       unused_imm_bits;

   logic       uses_rs;
   logic       uses_rt;
   logic       load_use;
   logic       br_hazard;
   logic       stall;

   state_e     state, state_nxt;
   logic [CNT_W-1:0] drain_cnt, drain_cnt_nxt;

   logic       redirect;
   logic [1:0] redirect_src;

   logic       pc_write;
   logic       ifid_write;
   logic       ifid_flush;
   logic       idex_bubble;
   logic [1:0] pc_src;
   logic       draining;
   logic       halted;

   assign op              = bus.id_instr[31:26];
   assign rs              = bus.id_instr[25:21];
   assign rt              = bus.id_instr[20:16];
   assign funct           = bus.id_instr[5:0];
   assign unused_imm_bits = ^bus.id_instr[15:6];

   hazard_unit u_hazard (
      .op           (op),
      .rs           (rs),
      .rt           (rt),
      .funct        (funct),
      .ex_reg_write (bus.ex_reg_write),
      .ex_mem_read  (bus.ex_mem_read),
      .ex_dst       (bus.ex_dst),
      .mem_mem_read (bus.mem_mem_read),
      .mem_dst      (bus.mem_dst),
      .uses_rs      (uses_rs),
      .uses_rt      (uses_rt),
      .load_use     (load_use),
      .br_hazard    (br_hazard)
   );

   assign stall = load_use | br_hazard;

   // Redirect decode for the ID-stage instruction (only honoured when not stalled).
   always_comb begin
      redirect     = 1'b0;
      redirect_src = PC_SRC_PC4;
      if ((op == OP_BEQ && bus.id_equal) || (op == OP_BNE && !bus.id_equal)) begin
         redirect     = 1'b1;
         redirect_src = PC_SRC_BRANCH;
      end else if (op == OP_J || op == OP_JAL) begin
         redirect     = 1'b1;
         redirect_src = PC_SRC_JUMP;
      end else if (op == OP_RTYPE && funct == FUNCT_JR) begin
         redirect     = 1'b1;
         redirect_src = PC_SRC_RS;
      end
   end

   // FSM next state, drain counter and pipeline control outputs.
   always_comb begin
      // NOTE: every output gets a default before any branch, so no path leaves one unassigned (no latch).
      state_nxt     = state;
      drain_cnt_nxt = drain_cnt;
      pc_write      = 1'b0;
      ifid_write    = 1'b0;
      ifid_flush    = 1'b0;
      idex_bubble   = 1'b1;
      pc_src        = PC_SRC_PC4;
      draining      = 1'b0;
      halted        = 1'b0;
      if (rst_n) begin
         case (state)
            RUN: begin
               pc_write    = 1'b1;
               ifid_write  = 1'b1;
               idex_bubble = 1'b0;
               if (stall) begin
                  pc_write    = 1'b0;
                  ifid_write  = 1'b0;
                  idex_bubble = 1'b1;
               end else if (bus.id_stop) begin
                  ifid_flush    = 1'b1;
                  idex_bubble   = 1'b1;
                  pc_write      = 1'b0;
                  state_nxt     = DRAIN;
                  drain_cnt_nxt = CNT_W'(DRAIN_CYCLES - 1);
               end else if (redirect) begin
                  pc_src     = redirect_src;
                  ifid_flush = 1'b1;
               end
            end
            DRAIN: begin
               draining = 1'b1;
               if (drain_cnt == '0) begin
                  state_nxt = HALT;
               end else begin
                  drain_cnt_nxt = drain_cnt - 1'b1;
               end
            end
            HALT: begin
               halted = 1'b1;
            end
            default: begin
               state_nxt = RUN;
            end
         endcase
      end
   end

   // State register and drain counter, synchronously reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      if (!rst_n) begin
         state     <= RUN;
         drain_cnt <= '0;
      end else begin
         state     <= state_nxt;
         drain_cnt <= drain_cnt_nxt;
      end
   end

`ifdef PIPE_CTRL_STATS_EN
   // Saturating statistics counters.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_cycles  <= '0;
         stat_stalls  <= '0;
         stat_flushes <= '0;
      end else begin
         if ((state == RUN || state == DRAIN) && !(&stat_cycles))
            stat_cycles <= stat_cycles + 1'b1;
         if (state == RUN && stall && !(&stat_stalls))
            stat_stalls <= stat_stalls + 1'b1;
         if (ifid_flush && !(&stat_flushes))
            stat_flushes <= stat_flushes + 1'b1;
      end
   end
`endif

   assign bus.pc_write    = pc_write;
   assign bus.ifid_write  = ifid_write;
   assign bus.ifid_flush  = ifid_flush;
   assign bus.idex_bubble = idex_bubble;
   assign bus.pc_src      = pc_src;
   assign bus.draining    = draining;
   assign bus.halted      = halted;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: a table of single-cycle RUN-state
// vectors plus hand-written sequences for stall release, stop/drain/halt and
// reset in the middle of a drain.
module tb_pipe_hazard_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   pipe_ctrl_if bus ();

`ifdef PIPE_CTRL_STATS_EN
   logic [31:0] stat_cycles, stat_stalls, stat_flushes;
`endif

   pipe_hazard_ctrl #(.DRAIN_CYCLES(3), .STAT_W(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus)
`ifdef PIPE_CTRL_STATS_EN
      ,
      .stat_cycles  (stat_cycles),
      .stat_stalls  (stat_stalls),
      .stat_flushes (stat_flushes)
`endif
   );

   // Expected control word {pc_write, ifid_write, ifid_flush, idex_bubble, pc_src}.
   localparam logic [5:0] E_NORM  = 6'b110000;
   localparam logic [5:0] E_STALL = 6'b000100;
   localparam logic [5:0] E_BR    = 6'b111001;
   localparam logic [5:0] E_JMP   = 6'b111010;
   localparam logic [5:0] E_JR    = 6'b111011;

   localparam logic [31:0] I_NOP    = 32'h0000_0000;
   localparam logic [31:0] I_STOP   = 32'hffff_ffff;
   localparam logic [31:0] I_ADD    = {6'h00, 5'd8, 5'd10, 5'd9, 5'd0, 6'h20};   // add $9,$8,$10
   localparam logic [31:0] I_ADD_R0 = {6'h00, 5'd0, 5'd0, 5'd1, 5'd0, 6'h20};   // add $1,$0,$0
   localparam logic [31:0] I_LW     = {6'h23, 5'd8, 5'd2, 16'h0000};            // lw $2,0($8)
   localparam logic [31:0] I_SW     = {6'h2b, 5'd8, 5'd2, 16'h0000};            // sw $2,0($8)
   localparam logic [31:0] I_BEQ    = {6'h04, 5'd8, 5'd9, 16'h0010};            // beq $8,$9
   localparam logic [31:0] I_BNE    = {6'h05, 5'd8, 5'd9, 16'h0010};            // bne $8,$9
   localparam logic [31:0] I_JR     = {6'h00, 5'd31, 5'd0, 5'd0, 5'd0, 6'h08};  // jr $31
   localparam logic [31:0] I_J      = {6'h02, 5'd8, 21'h000100};                // j (bits 25:21 = 8)
   localparam logic [31:0] I_JAL    = {6'h03, 26'h0000010};                     // jal

   typedef struct {
      string       name;
      logic [31:0] instr;
      logic        eq;
      logic        ex_rw;
      logic        ex_mr;
      logic [4:0]  ex_dst;
      logic        mem_mr;
      logic [4:0]  mem_dst;
      logic [5:0]  exp;
   } vec_t;

   localparam int NVEC = 20;
   vec_t vecs [NVEC];

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [31:0] instr, input logic eq, input logic ex_rw,
                        input logic ex_mr, input logic [4:0] ex_dst,
                        input logic mem_mr, input logic [4:0] mem_dst);
      bus.id_instr     = instr;
      bus.id_stop      = (instr == 32'hffff_ffff);
      bus.id_equal     = eq;
      bus.ex_reg_write = ex_rw;
      bus.ex_mem_read  = ex_mr;
      bus.ex_dst       = ex_dst;
      bus.mem_mem_read = mem_mr;
      bus.mem_dst      = mem_dst;
   endtask

   function automatic logic [5:0] ctrl();
      return {bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idex_bubble, bus.pc_src};
   endfunction

   function automatic logic [7:0] ctrl_fsm();
      return {ctrl(), bus.draining, bus.halted};
   endfunction

   // One edge with rst_n low, released at the following falling edge with a NOP in ID.
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      drive(I_NOP, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      vecs[0]  = '{"nop",             I_NOP,    1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  E_NORM};
      vecs[1]  = '{"load_use_rs",     I_ADD,    1'b0, 1'b1, 1'b1, 5'd8,  1'b0, 5'd0,  E_STALL};
      vecs[2]  = '{"load_use_rt",     I_ADD,    1'b0, 1'b1, 1'b1, 5'd10, 1'b0, 5'd0,  E_STALL};
      vecs[3]  = '{"alu_fwd_no_stall",I_ADD,    1'b0, 1'b1, 1'b0, 5'd8,  1'b0, 5'd0,  E_NORM};
      vecs[4]  = '{"lw_rt_unused",    I_LW,     1'b0, 1'b1, 1'b1, 5'd2,  1'b0, 5'd0,  E_NORM};
      vecs[5]  = '{"sw_rt_used",      I_SW,     1'b0, 1'b1, 1'b1, 5'd2,  1'b0, 5'd0,  E_STALL};
      vecs[6]  = '{"beq_taken",       I_BEQ,    1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  E_BR};
      vecs[7]  = '{"beq_not_taken",   I_BEQ,    1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  E_NORM};
      vecs[8]  = '{"bne_taken",       I_BNE,    1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  E_BR};
      vecs[9]  = '{"bne_not_taken",   I_BNE,    1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  E_NORM};
      vecs[10] = '{"beq_ex_alu_haz",  I_BEQ,    1'b1, 1'b1, 1'b0, 5'd8,  1'b0, 5'd0,  E_STALL};
      vecs[11] = '{"beq_mem_load_rt", I_BEQ,    1'b1, 1'b0, 1'b0, 5'd0,  1'b1, 5'd9,  E_STALL};
      vecs[12] = '{"beq_mem_alu_ok",  I_BEQ,    1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 5'd8,  E_BR};
      vecs[13] = '{"jr31",            I_JR,     1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  E_JR};
      vecs[14] = '{"jr_ex_haz",       I_JR,     1'b0, 1'b1, 1'b0, 5'd31, 1'b0, 5'd0,  E_STALL};
      vecs[15] = '{"j_no_rs_use",     I_J,      1'b0, 1'b1, 1'b1, 5'd8,  1'b0, 5'd0,  E_JMP};
      vecs[16] = '{"jal",             I_JAL,    1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  E_JMP};
      vecs[17] = '{"r0_never_match",  I_ADD_R0, 1'b0, 1'b1, 1'b1, 5'd0,  1'b0, 5'd0,  E_NORM};
      vecs[18] = '{"add_mem_load_ok", I_ADD,    1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 5'd8,  E_NORM};
      vecs[19] = '{"beq_load_use",    I_BEQ,    1'b1, 1'b1, 1'b1, 5'd8,  1'b0, 5'd0,  E_STALL};

      // Reset state: outputs forced while rst_n is low.
      rst_n = 1'b0;
      drive(I_NOP, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
      #1 check("reset_comb", {24'd0, ctrl_fsm()}, 32'h10);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_held", {24'd0, ctrl_fsm()}, 32'h10);
`ifdef PIPE_CTRL_STATS_EN
      check("reset_stat_cycles", stat_cycles, 32'd0);
      check("reset_stat_stalls", stat_stalls, 32'd0);
`endif
      rst_n = 1'b1;

      // Load-use stall lasts exactly one cycle once the bubble reaches EX.
      drive(I_ADD, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0);
      #1 check("lu_seq_stall", {26'd0, ctrl()}, {26'd0, E_STALL});
`ifdef PIPE_CTRL_STATS_EN
      check("lu_seq_stat_before", stat_stalls, 32'd0);
`endif
      @(negedge clk);
`ifdef PIPE_CTRL_STATS_EN
      check("lu_seq_stat_after", stat_stalls, 32'd1);
`endif
      drive(I_ADD, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
      #1 check("lu_seq_release", {26'd0, ctrl()}, {26'd0, E_NORM});
      @(negedge clk);
`ifdef PIPE_CTRL_STATS_EN
      check("lu_seq_stat_hold", stat_stalls, 32'd1);
`endif

      // Branch operand hazard, then the taken redirect once it clears.
      drive(I_BEQ, 1'b1, 1'b1, 1'b0, 5'd8, 1'b0, 5'd0);
      #1 check("br_seq_stall", {26'd0, ctrl()}, {26'd0, E_STALL});
      @(negedge clk);
      drive(I_BEQ, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
      #1 check("br_seq_taken", {26'd0, ctrl()}, {26'd0, E_BR});
      @(negedge clk);
`ifdef PIPE_CTRL_STATS_EN
      check("br_seq_stat_stalls", stat_stalls, 32'd2);
      check("br_seq_stat_flushes", stat_flushes, 32'd1);
`endif

      // Single-cycle vector table in RUN.
      for (int i = 0; i < NVEC; i++) begin
         @(negedge clk);
         drive(vecs[i].instr, vecs[i].eq, vecs[i].ex_rw, vecs[i].ex_mr, vecs[i].ex_dst,
               vecs[i].mem_mr, vecs[i].mem_dst);
         #1 check(vecs[i].name, {26'd0, ctrl()}, {26'd0, vecs[i].exp});
      end

      // Stop word: flush cycle, three DRAIN cycles, then HALT.
      do_reset();
      drive(I_STOP, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
      #1 check("stop_accept", {24'd0, ctrl_fsm()}, {24'd0, 8'b01110000});
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drive(I_NOP, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
         #1 check($sformatf("drain_%0d", i), {24'd0, ctrl_fsm()}, {24'd0, 8'b00010010});
      end
      @(negedge clk);
      check("halt_entry", {24'd0, ctrl_fsm()}, {24'd0, 8'b00010001});
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check($sformatf("halt_hold_%0d", i), {30'd0, bus.pc_write, bus.halted}, 32'd1);
      end

      // Reset during the second DRAIN cycle returns to RUN.
      do_reset();
      drive(I_STOP, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
      #1 check("rst_drain_stop", {24'd0, ctrl_fsm()}, {24'd0, 8'b01110000});
      @(negedge clk);
      drive(I_NOP, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
      #1 check("rst_drain_1st", {30'd0, bus.draining, bus.halted}, 32'd2);
      @(negedge clk);
      check("rst_drain_2nd", {30'd0, bus.draining, bus.halted}, 32'd2);
      rst_n = 1'b0;
      #1 check("rst_drain_forced", {24'd0, ctrl_fsm()}, 32'h10);
      @(negedge clk);
      rst_n = 1'b1;
      #1 check("rst_drain_run", {24'd0, ctrl_fsm()}, {24'd0, E_NORM, 2'b00});
`ifdef PIPE_CTRL_STATS_EN
      check("rst_drain_stat_flushes", stat_flushes, 32'd0);
      check("rst_drain_stat_stalls", stat_stalls, 32'd0);
`endif
      @(negedge clk);
      check("rst_drain_run_next", {24'd0, ctrl_fsm()}, {24'd0, E_NORM, 2'b00});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
